// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the two-master Wishbone arbiter:
//   - arbiter FSM state encoding (IDLE / GNT0 / GNT1)
//   - one-hot grant constants as seen on gnt_o
//   - default address/data widths
// No ports (package).
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_AW_DEF = 32;
    localparam int WB_DW_DEF = 32;

    // State values double as the one-hot grant vector (GNT0 = 01, GNT1 = 10).
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arbiter2_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter2_if
// Classic single-beat Wishbone bus bundle.
//   Request  (master -> slave): cyc, stb, we, adr[AW], sel[DW/8], dat_w[DW]
//   Response (slave -> master): dat_r[DW], ack, err, rty
// Modports:
//   master - the side that issues cycles (drives the request fields)
//   slave  - the side that answers cycles (drives the response fields)
// ---------------------------------------------------------------------------
interface wb_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;
    logic            rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, rty
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_arb_watchdog
// Stall counter for the arbiter's bus watchdog. The module only exists when
// WB_ARB_TIMEOUT_EN is defined; otherwise this file is empty.
// Ports:
//   clk_i     clock
//   rst_ni    synchronous active-low reset
//   en_i      one stalled cycle (strobe pending, no slave response)
//   clr_i     clear the count (response seen, or arbiter idle)
//   expire_o  high for the single cycle that is the LIMIT-th stalled cycle
// ---------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count holds the number of stalls already seen, so the LIMIT-th
    // stall is the one arriving while the count sits at LIMIT-1.
    assign expire_o = en_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2
// Two-master round-robin Wishbone (classic, single-beat) arbiter driving one
// slave-side bus. Master 0 is the CPU, master 1 a secondary master (DMA/debug).
// A grant is held for as long as the granted master keeps cyc high; every
// handover passes through one IDLE cycle.
// Ports:
//   clk_i   clock (rising edge)
//   rst_ni  synchronous active-low reset
//   m0, m1  master-facing buses (requests in, responses out, gated by grant)
//   s       slave-facing bus (muxed request out, responses in)
//   gnt_o   one-hot current grant, 2'b00 when idle
// Configuration:
//   WB_ARB_TIMEOUT_EN - when defined, a stalled strobe lasting TIMEOUT_CYCLES
//   cycles is answered with a one-cycle err to the granted master and the
//   slave strobe is withdrawn for that cycle.
// ---------------------------------------------------------------------------
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int AW             = WB_AW_DEF,
    parameter int DW             = WB_DW_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    wb_arbiter2_if.slave        m0,
    wb_arbiter2_if.slave        m1,
    wb_arbiter2_if.master       s,
    output logic [1:0]          gnt_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT_CYCLES must be within 1..65535");
    end

    arb_state_e state_q, state_d;
    logic       last_q, last_d;   // index of the master that won most recently

    logic            cyc_mux;
    logic            stb_mux;
    logic            we_mux;
    logic [AW-1:0]   adr_mux;
    logic [DW/8-1:0] sel_mux;
    logic [DW-1:0]   dat_mux;
    logic            slv_resp;
    logic            wd_expire;

    assign slv_resp = s.ack | s.err | s.rty;

    // ---------------- grant FSM ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;          // so master 0 wins the first tie
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    if (last_q) begin
                        state_d = ARB_GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ARB_GNT1;
                        last_d  = 1'b1;
                    end
                end else if (m0.cyc) begin
                    state_d = ARB_GNT0;
                    last_d  = 1'b0;
                end else if (m1.cyc) begin
                    state_d = ARB_GNT1;
                    last_d  = 1'b1;
                end
            end
            ARB_GNT0: if (!m0.cyc) state_d = ARB_IDLE;
            ARB_GNT1: if (!m1.cyc) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // ---------------- request mux / response gating ----------------
    always_comb begin
        gnt_o   = GNT_NONE;
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = '0;
        sel_mux = '0;
        dat_mux = '0;
        m0.ack  = 1'b0;
        m0.err  = 1'b0;
        m0.rty  = 1'b0;
        m1.ack  = 1'b0;
        m1.err  = 1'b0;
        m1.rty  = 1'b0;
        case (state_q)
            ARB_GNT0: begin
                gnt_o   = GNT_M0;
                cyc_mux = m0.cyc;
                stb_mux = m0.stb;
                we_mux  = m0.we;
                adr_mux = m0.adr;
                sel_mux = m0.sel;
                dat_mux = m0.dat_w;
                m0.ack  = s.ack;
                m0.err  = s.err | wd_expire;
                m0.rty  = s.rty;
            end
            ARB_GNT1: begin
                gnt_o   = GNT_M1;
                cyc_mux = m1.cyc;
                stb_mux = m1.stb;
                we_mux  = m1.we;
                adr_mux = m1.adr;
                sel_mux = m1.sel;
                dat_mux = m1.dat_w;
                m1.ack  = s.ack;
                m1.err  = s.err | wd_expire;
                m1.rty  = s.rty;
            end
            default: ;
        endcase
    end

    assign s.cyc   = cyc_mux;
    assign s.stb   = stb_mux & ~wd_expire;
    assign s.we    = we_mux;
    assign s.adr   = adr_mux;
    assign s.sel   = sel_mux;
    assign s.dat_w = dat_mux;

    // Read data is not qualified by grant; masters only look at it on ack.
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    // ---------------- optional watchdog ----------------
`ifdef WB_ARB_TIMEOUT_EN
    logic wd_stall;
    logic wd_clr;

    // Stall uses the un-forced strobe so the expire pulse does not feed back.
    assign wd_stall = cyc_mux & stb_mux & ~slv_resp;
    // Every grant change passes through IDLE, so clearing there covers it.
    assign wd_clr   = (state_q == ARB_IDLE) | slv_resp;

    wb_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (wd_stall),
        .clr_i    (wd_clr),
        .expire_o (wd_expire)
    );
`else
    logic unused_resp;
    assign unused_resp = slv_resp;
    assign wd_expire   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2
// Directed bench for wb_arbiter2 with TIMEOUT_CYCLES = 8. Each scenario task
// drives the buses and checks outputs against hand-computed values.
// Honours WB_ARB_TIMEOUT_EN for the hung-slave scenario.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;

`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    wb_arbiter2_if #(.AW(AW), .DW(DW)) m0_bus ();
    wb_arbiter2_if #(.AW(AW), .DW(DW)) m1_bus ();
    wb_arbiter2_if #(.AW(AW), .DW(DW)) s_bus ();

    wb_arbiter2 #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m0     (m0_bus),
        .m1     (m1_bus),
        .s      (s_bus),
        .gnt_o  (gnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
        m0_bus.adr = '0;   m0_bus.sel = '0;   m0_bus.dat_w = '0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        m1_bus.adr = '0;   m1_bus.sel = '0;   m1_bus.dat_w = '0;
        s_bus.ack = 1'b0;  s_bus.err = 1'b0;  s_bus.rty = 1'b0;
        s_bus.dat_r = '0;
    endtask

    task automatic test_reset();
        clear_all();
        rst_n = 1'b0;
        step();
        step();
        if (gnt !== 2'b00) begin
            $display("FAIL reset_gnt: got %b expected %b", gnt, 2'b00); n_bad++;
        end
        n_cmp++;
        if (s_bus.cyc !== 1'b0) begin
            $display("FAIL reset_s_cyc: got %b expected 0", s_bus.cyc); n_bad++;
        end
        n_cmp++;
        if ({m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty} !== 6'b0) begin
            $display("FAIL reset_resp: got %b expected 000000",
                     {m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty});
            n_bad++;
        end
        n_cmp++;
        $display("txn reset: gnt=%b s_cyc=%b", gnt, s_bus.cyc);
    endtask

    task automatic test_single_read();
        rst_n = 1'b1;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = 1'b0;
        m0_bus.adr = 32'h1000_0004; m0_bus.sel = 4'hF;
        #1;
        if (s_bus.cyc !== 1'b0) begin
            $display("FAIL read_latency: s_cyc got %b expected 0", s_bus.cyc); n_bad++;
        end
        n_cmp++;
        step();
        if (gnt !== 2'b01) begin
            $display("FAIL read_gnt: got %b expected 01", gnt); n_bad++;
        end
        n_cmp++;
        if ({s_bus.cyc, s_bus.stb, s_bus.we} !== 3'b110) begin
            $display("FAIL read_ctrl: got %b expected 110", {s_bus.cyc, s_bus.stb, s_bus.we}); n_bad++;
        end
        n_cmp++;
        if (s_bus.adr !== 32'h1000_0004) begin
            $display("FAIL read_adr: got %h expected 10000004", s_bus.adr); n_bad++;
        end
        n_cmp++;
        s_bus.ack = 1'b1; s_bus.dat_r = 32'hCAFE_BABE;
        #1;
        if (m0_bus.ack !== 1'b1) begin
            $display("FAIL read_m0_ack: got %b expected 1", m0_bus.ack); n_bad++;
        end
        n_cmp++;
        if (m0_bus.dat_r !== 32'hCAFE_BABE) begin
            $display("FAIL read_m0_dat: got %h expected cafebabe", m0_bus.dat_r); n_bad++;
        end
        n_cmp++;
        if (m1_bus.ack !== 1'b0) begin
            $display("FAIL read_m1_ack: got %b expected 0", m1_bus.ack); n_bad++;
        end
        n_cmp++;
        $display("txn m0 read adr=%h dat=%h", s_bus.adr, m0_bus.dat_r);
        step();
        clear_all();
        step();
        if (gnt !== 2'b00) begin
            $display("FAIL read_release: gnt got %b expected 00", gnt); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_tie_alternation();
        clear_all();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        step();
        if (gnt !== 2'b01) begin
            $display("FAIL tie_first: gnt got %b expected 01", gnt); n_bad++;
        end
        n_cmp++;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        step();
        if (gnt !== 2'b00) begin
            $display("FAIL tie_dead_cycle: gnt got %b expected 00", gnt); n_bad++;
        end
        n_cmp++;
        if (s_bus.cyc !== 1'b0) begin
            $display("FAIL tie_dead_s_cyc: got %b expected 0", s_bus.cyc); n_bad++;
        end
        n_cmp++;
        step();
        if (gnt !== 2'b10) begin
            $display("FAIL tie_handover: gnt got %b expected 10", gnt); n_bad++;
        end
        n_cmp++;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        step();
        if (gnt !== 2'b01) begin
            $display("FAIL tie_alternate: gnt got %b expected 01", gnt); n_bad++;
        end
        n_cmp++;
        $display("txn tie sequence: final gnt=%b", gnt);
        clear_all();
        step();
    endtask

    task automatic test_m1_write();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b1;
        m1_bus.adr = 32'h4000_0000; m1_bus.dat_w = 32'h3; m1_bus.sel = 4'h1;
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = 1'b0;
        m0_bus.adr = 32'h1000_0008; m0_bus.dat_w = 32'h0000_FFFF; m0_bus.sel = 4'hF;
        #1;
        if (gnt !== 2'b10) begin
            $display("FAIL wr_gnt: got %b expected 10", gnt); n_bad++;
        end
        n_cmp++;
        if ({s_bus.adr, s_bus.dat_w} !== {32'h4000_0000, 32'h3}) begin
            $display("FAIL wr_adr_dat: got %h/%h expected 40000000/00000003", s_bus.adr, s_bus.dat_w);
            n_bad++;
        end
        n_cmp++;
        if ({s_bus.sel, s_bus.we} !== {4'h1, 1'b1}) begin
            $display("FAIL wr_sel_we: got %h/%b expected 1/1", s_bus.sel, s_bus.we); n_bad++;
        end
        n_cmp++;
        s_bus.ack = 1'b1;
        #1;
        if ({m1_bus.ack, m0_bus.ack} !== 2'b10) begin
            $display("FAIL wr_ack_route: got m1/m0 %b expected 10", {m1_bus.ack, m0_bus.ack}); n_bad++;
        end
        n_cmp++;
        step();
        if (s_bus.adr !== 32'h4000_0000) begin
            $display("FAIL wr_hold_adr: got %h expected 40000000", s_bus.adr); n_bad++;
        end
        n_cmp++;
        $display("txn m1 write adr=%h dat=%h sel=%h", s_bus.adr, s_bus.dat_w, s_bus.sel);
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; s_bus.ack = 1'b0;
        step();
        if ({gnt, s_bus.adr} !== {2'b00, 32'h0}) begin
            $display("FAIL wr_release: got gnt %b adr %h expected 00 00000000", gnt, s_bus.adr); n_bad++;
        end
        n_cmp++;
        step();
        if ({gnt, s_bus.adr, s_bus.we} !== {2'b01, 32'h1000_0008, 1'b0}) begin
            $display("FAIL wr_next_m0: got gnt %b adr %h we %b expected 01 10000008 0",
                     gnt, s_bus.adr, s_bus.we);
            n_bad++;
        end
        n_cmp++;
        $display("txn m0 granted after m1 adr=%h", s_bus.adr);
    endtask

    task automatic test_mid_drop();
        clear_all();
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h1000_0010; m0_bus.sel = 4'hF;
        step();
        if (s_bus.cyc !== 1'b1) begin
            $display("FAIL drop_pre: s_cyc got %b expected 1", s_bus.cyc); n_bad++;
        end
        n_cmp++;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        #1;
        if ({s_bus.cyc, s_bus.stb} !== 2'b00) begin
            $display("FAIL drop_same_cycle: s_cyc/stb got %b expected 00", {s_bus.cyc, s_bus.stb});
            n_bad++;
        end
        n_cmp++;
        step();
        s_bus.ack = 1'b1;
        #1;
        if ({m0_bus.ack, m1_bus.ack} !== 2'b00) begin
            $display("FAIL drop_late_ack: got %b expected 00", {m0_bus.ack, m1_bus.ack}); n_bad++;
        end
        n_cmp++;
        $display("txn m0 dropped cyc, late ack blocked gnt=%b", gnt);
        s_bus.ack = 1'b0;
    endtask

    task automatic test_timeout();
        logic exp_err;
        clear_all();
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h2000_0000; m0_bus.sel = 4'hF;
        step();
        for (int k = 1; k <= 100; k++) begin
            exp_err = TO_EN && ((k % 8) == 0);
            if (m0_bus.err !== exp_err) begin
                $display("FAIL timeout_err_c%0d: got %b expected %b", k, m0_bus.err, exp_err); n_bad++;
            end
            n_cmp++;
            if (s_bus.stb !== !exp_err) begin
                $display("FAIL timeout_stb_c%0d: got %b expected %b", k, s_bus.stb, !exp_err); n_bad++;
            end
            n_cmp++;
            step();
        end
        $display("txn hung slave: 100 stalled cycles, watchdog enabled=%0d", TO_EN);
        clear_all();
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_alternation();
        test_m1_write();
        test_mid_drop();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
